// File: rtl/uart_pkg.sv
// Shared definitions for the UART command decoder: opcodes, error causes and parser states.
package uart_pkg;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_CLEAR = 4'h2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_CHK,
        S_SKIP
    } state_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle-cycle counter: cleared by i_clr, counts while i_en, flags when it sits at TIMEOUT-1.
module uart_idle_timer #(
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_en && !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses framed 16-bit command words into shadow registers and commits them to the live
// bank only when the frame checksum matches.
module uart_cmd_decoder
    import uart_pkg::*;
#(
    parameter int unsigned NREG    = 8,
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_set,
    input  logic [15:0]          i_setdata,
    output logic [16*NREG-1:0]   o_regs,
    output logic                 o_commit,
    output logic                 o_err,
    output logic [1:0]           o_err_code,
    output logic                 o_busy
);

    state_e      state_q, state_d;
    logic [4:0]  start_q, start_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  idx_q, idx_d;
    logic [8:0]  skip_q, skip_d;
    logic [15:0] xor_q, xor_d;
    logic        clear_q, clear_d;
    logic [15:0] shadow_q [NREG];
    logic [15:0] shadow_d [NREG];
    logic [15:0] regs_q [NREG];
    logic [15:0] regs_d [NREG];
    logic        commit_q, commit_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        busy_q;

    logic        expired;
    logic [3:0]  hdr_op;
    logic [7:0]  hdr_count;
    logic [8:0]  hdr_end;
    logic        wr_ok, clr_ok;
    logic [4:0]  wr_addr;

    uart_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_set || (state_q == S_HDR)),
        .i_en      (state_q != S_HDR),
        .o_expired (expired)
    );

    // Range check is widened so start+count can never wrap past NREG.
    assign hdr_op    = i_setdata[15:12];
    assign hdr_count = i_setdata[7:0];
    assign hdr_end   = {5'd0, i_setdata[11:8]} + {1'b0, hdr_count};
    assign wr_ok     = (hdr_op == OP_WRITE) && (hdr_count != 8'd0) && (hdr_end <= 9'(NREG));
    assign clr_ok    = (hdr_op == OP_CLEAR) && (hdr_count == 8'd0);
    assign wr_addr   = start_q + idx_q[4:0];

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        count_d  = count_q;
        idx_d    = idx_q;
        skip_d   = skip_q;
        xor_d    = xor_q;
        clear_d  = clear_q;
        shadow_d = shadow_q;
        regs_d   = regs_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        unique case (state_q)
            S_HDR: begin
                if (i_set) begin
                    start_d  = {1'b0, i_setdata[11:8]};
                    count_d  = hdr_count;
                    idx_d    = 8'd0;
                    xor_d    = i_setdata;
                    clear_d  = (hdr_op == OP_CLEAR);
                    shadow_d = regs_q;
                    if (wr_ok) begin
                        state_d = S_DATA;
                    end else if (clr_ok) begin
                        state_d = S_CHK;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_FRAME;
                        skip_d  = {1'b0, hdr_count} + 9'd1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_DATA: begin
                if (i_set) begin
                    for (int k = 0; k < NREG; k++) begin
                        if (wr_addr == 5'(k)) begin
                            shadow_d[k] = i_setdata;
                        end
                    end
                    xor_d = xor_q ^ i_setdata;
                    idx_d = idx_q + 8'd1;
                    if ((idx_q + 8'd1) == count_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_set) begin
                    if (i_setdata == xor_q) begin
                        for (int k = 0; k < NREG; k++) begin
                            regs_d[k] = clear_q ? 16'd0 : shadow_q[k];
                        end
                        commit_d = 1'b1;
                        code_d   = ERR_NONE;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                    state_d = S_HDR;
                end
            end
            S_SKIP: begin
                if (i_set) begin
                    skip_d = skip_q - 9'd1;
                    if (skip_q == 9'd1) begin
                        state_d = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase

        // A word arriving in the expiry cycle wins; the timer only fires on idle cycles.
        if (!i_set && expired) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_HDR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_HDR;
            start_q  <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            skip_q   <= '0;
            xor_q    <= '0;
            clear_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            busy_q   <= 1'b0;
            for (int k = 0; k < NREG; k++) begin
                shadow_q[k] <= '0;
                regs_q[k]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            skip_q   <= skip_d;
            xor_q    <= xor_d;
            clear_q  <= clear_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            code_q   <= code_d;
            busy_q   <= (state_d != S_HDR);
            shadow_q <= shadow_d;
            regs_q   <= regs_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign o_regs[16*g +: 16] = regs_q[g];
    end

    assign o_commit   = commit_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes the 16-bit words the UART bridge assembles from received byte pairs (word strobe plus data).
- Parses them into framed configuration commands and stages payloads in shadow registers.
- Commits the shadow registers atomically to a live register bank only after the checksum matches.
- Sits directly downstream of the UART bridge and feeds configuration registers to the rest of the design.

Parameters:
- NREG, 8, number of 16-bit live registers (power of two, ≤16).
- TIMEOUT, 50000000, maximum idle cycles between words of one frame before the frame is abandoned.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_set  in  1  one-cycle strobe: i_setdata holds a new word
- i_setdata  in  16  received word
- o_regs  out  16*NREG  live registers, flat; reg k occupies bits [16k+15:16k]
- o_commit  out  1  one-cycle pulse: o_regs just updated
- o_err  out  1  one-cycle pulse: frame rejected
- o_err_code  out  2  last error cause, held until the next error or commit
- o_busy  out  1  high whenever the parser is not waiting for a header

Behaviour:
- Reset: one clock, asynchronous active-low. On reset, all of the following clear to 0:
  - o_regs, shadow registers, o_commit, o_err, o_err_code, o_busy;
  - state = S_HDR; word and timeout counters.
- Frame format:
  - Header word: [15:12] opcode, [11:8] start address, [7:0] count.
  - Then count payload words.
  - Then a checksum word equal to the XOR of the header and all payload words.
- Opcodes:
  - OP_WRITE = 4'h1: requires 1 ≤ count and start+count ≤ NREG.
  - OP_CLEAR = 4'h2: requires count = 0; on commit, all registers go to 0.
- States:
  - S_HDR: on i_set, latch the header, init the running XOR with it, copy live into shadow.
    - Valid WRITE → S_DATA. Valid CLEAR → S_CHK.
    - Unknown opcode, or count/range violation → pulse o_err with code ERR_FRAME; skip counter = count+1; go to S_SKIP.
  - S_DATA: on each i_set, write shadow[start+idx], XOR into the checksum, idx++. After word count → S_CHK.
  - S_CHK: on i_set:
    - Match → at the same edge, live ← shadow (or all-zero for CLEAR); o_commit=1 for the next cycle; o_err_code ← ERR_NONE; → S_HDR.
    - Mismatch → o_err pulse, code ERR_CHK, live untouched, → S_HDR.
  - S_SKIP: discard words, decrementing the skip counter on each i_set. At 0 → S_HDR. No further o_err pulse.
- Latency: o_regs, o_commit and o_err change exactly one cycle after the edge that samples the relevant i_set.
- Timeout:
  - The counter clears on every i_set and while in S_HDR; otherwise it increments.
  - When it reaches TIMEOUT-1 in S_DATA, S_CHK or S_SKIP: pulse o_err, code ERR_TIMEOUT; discard the shadow; → S_HDR.
  - If i_set arrives in that same cycle, the word is consumed normally and the timeout is cancelled.
- Edge cases:
  - Address arithmetic is done in 5 bits so that start+count cannot wrap.
  - o_busy = (state != S_HDR), registered.
  - i_setdata is ignored when i_set=0.
  - Reset mid-frame discards the frame; live registers clear.

Decomposition:
- Shared package uart_pkg holds:
  - opcode constants OP_WRITE and OP_CLEAR;
  - error codes ERR_NONE=0, ERR_CHK=1, ERR_FRAME=2, ERR_TIMEOUT=3;
  - the state enum {S_HDR, S_DATA, S_CHK, S_SKIP}.
- One natural sub-module, uart_idle_timer: parameterised TIMEOUT counter with clear/enable inputs and an expiry output.

Test Plan:
- Write frame: i_set words 1202, ABCD, 1234, ABFB → one cycle later reg2=ABCD, reg3=1234, o_commit pulses once, other regs unchanged, o_err_code=0.
- Clear frame: after the write test, send 2000, 2000 → all o_regs=0, o_commit pulse.
- Bad checksum: send 1101, 5555, 0000 → o_err pulse, o_err_code=1, reg1 unchanged. A following valid frame still commits.
- Frame error: send 1705 (7+5>8) → o_err with code 2; the next 6 words, including valid-looking headers, are ignored; the 7th word is parsed as a header.
- Timeout: with TIMEOUT=20, send 1001, then idle 20 cycles → o_err, code 3, o_busy falls. A subsequent 1001,0042,1043 commits reg0=0042.
- Reset mid-frame: assert i_rst low after 1202, ABCD → all outputs 0 immediately, state S_HDR. After release, a full write frame works.
